// File: rtl/qspi_pkg.sv
// Shared types and sizes for the host-side QSPI bridge.
package qspi_pkg;

  localparam int unsigned NIB_W          = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned KEY_WIDTH_DFLT = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PROG,
    S_WAIT_K,
    S_PRE_K,
    S_KEY,
    S_GAP_K,
    S_WAIT_D,
    S_PRE_D,
    S_HI,
    S_LO,
    S_END
  } tx_state_e;

endpackage

// File: rtl/qspi_host_bridge_if.sv
// Host-side bundle: session control, TX byte stream, both QSPI links, RX byte stream.
interface qspi_host_bridge_if
  import qspi_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = KEY_WIDTH_DFLT
) ();

  logic                 start;
  logic [KEY_WIDTH-1:0] key;
  logic [BYTE_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 tx_last;
  logic                 tx_ready;
  logic                 prog;
  logic [NIB_W-1:0]     qspi_data_o;
  logic                 qspi_sending_o;
  logic                 qspi_ready_i;
  logic [NIB_W-1:0]     qspi_data_i;
  logic                 qspi_sending_i;
  logic                 qspi_ready_o;
  logic [BYTE_W-1:0]    rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 done;
  logic                 underrun;
  logic                 rx_drop;

  // The bridge itself
  modport slave (
    input  start, key, tx_data, tx_valid, tx_last, qspi_ready_i,
           qspi_data_i, qspi_sending_i, rx_ready,
    output tx_ready, prog, qspi_data_o, qspi_sending_o, qspi_ready_o,
           rx_data, rx_valid, busy, done, underrun, rx_drop
  );

  // Whatever drives the bridge (host logic or a bench)
  modport master (
    output start, key, tx_data, tx_valid, tx_last, qspi_ready_i,
           qspi_data_i, qspi_sending_i, rx_ready,
    input  tx_ready, prog, qspi_data_o, qspi_sending_o, qspi_ready_o,
           rx_data, rx_valid, busy, done, underrun, rx_drop
  );

endinterface

// File: rtl/qspi_nibble_rx.sv
// Reassembles Collector nibbles (high first) into bytes with valid/ready backpressure.
module qspi_nibble_rx
  import qspi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [NIB_W-1:0]  nib,
  input  logic              sending,
  input  logic              rx_ready,
  output logic              ready_c,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_drop
);

  logic             phase_q;
  logic [NIB_W-1:0] hi_q;
  logic             accept;

  // Stall the Collector only while a finished byte is waiting to be taken
  assign ready_c = !(rx_valid && !rx_ready);
  assign accept  = sending && ready_c;

  // Nibble phase, byte assembly and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= 1'b0;
      hi_q     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_drop  <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (clear) rx_drop <= 1'b0;
      if (accept) begin
        if (!phase_q) begin
          hi_q    <= nib;
          phase_q <= 1'b1;
        end else begin
          rx_data  <= {hi_q, nib};
          rx_valid <= 1'b1;
          phase_q  <= 1'b0;
        end
      end else if (!sending && phase_q) begin
        // Burst ended on a half byte: throw it away and resync
        phase_q <= 1'b0;
        rx_drop <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/qspi_host_bridge.sv
// Host-side QSPI endpoint: TX session FSM toward the Parallelizer, RX reassembly from the Collector.
module qspi_host_bridge
  import qspi_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = KEY_WIDTH_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  qspi_host_bridge_if.slave  bus
);

  localparam int unsigned KEY_NIBBLES = KEY_WIDTH / NIB_W;
  localparam int unsigned IDX_W       = (KEY_NIBBLES > 1) ? $clog2(KEY_NIBBLES) : 1;

  tx_state_e            state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 underrun_q, underrun_d;
  logic                 start_acc;
  logic                 prog_c, busy_c, done_c, sending_c, tx_ready_c;
  logic [NIB_W-1:0]     data_c;
  logic [NIB_W-1:0]     key_nib;

  logic                 rx_ready_c;
  logic [BYTE_W-1:0]    rx_data;
  logic                 rx_valid;
  logic                 rx_drop;

  assign key_nib = key_q[32'(idx_q) * NIB_W +: NIB_W];

  // TX state, latched key, key nibble index, sticky underrun
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      idx_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      underrun_q <= underrun_d;
    end
  end

  // TX next-state and per-state outputs
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    idx_d      = idx_q;
    underrun_d = underrun_q;
    start_acc  = 1'b0;
    prog_c     = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    sending_c  = 1'b0;
    tx_ready_c = 1'b0;
    data_c     = '0;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          start_acc  = 1'b1;
          key_d      = bus.key;
          underrun_d = 1'b0;
          state_d    = S_PROG;
        end
      end
      S_PROG: begin
        prog_c  = 1'b1;
        state_d = S_WAIT_K;
      end
      S_WAIT_K: begin
        if (bus.qspi_ready_i) state_d = S_PRE_K;
      end
      S_PRE_K: begin
        sending_c = 1'b1;
        idx_d     = IDX_W'(KEY_NIBBLES - 1);
        state_d   = S_KEY;
      end
      S_KEY: begin
        sending_c = 1'b1;
        data_c    = key_nib;
        if (bus.qspi_ready_i) begin
          if (idx_q == '0) state_d = S_GAP_K;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      S_GAP_K: begin
        state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (bus.qspi_ready_i && bus.tx_valid) state_d = S_PRE_D;
      end
      S_PRE_D: begin
        sending_c = 1'b1;
        state_d   = S_HI;
      end
      S_HI: begin
        // A starved stream must not push a stale nibble into the Parallelizer
        sending_c = bus.tx_valid;
        data_c    = bus.tx_data[7:4];
        if (!bus.tx_valid) begin
          underrun_d = 1'b1;
          state_d    = S_END;
        end else if (bus.qspi_ready_i) begin
          state_d = S_LO;
        end
      end
      S_LO: begin
        sending_c = 1'b1;
        data_c    = bus.tx_data[3:0];
        if (bus.qspi_ready_i) begin
          tx_ready_c = 1'b1;
          state_d    = bus.tx_last ? S_END : S_HI;
        end
      end
      S_END: begin
        busy_c  = 1'b0;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_c  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  qspi_nibble_rx u_rx (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_acc),
    .nib      (bus.qspi_data_i),
    .sending  (bus.qspi_sending_i),
    .rx_ready (bus.rx_ready),
    .ready_c  (rx_ready_c),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_drop  (rx_drop)
  );

  assign bus.prog           = prog_c;
  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.qspi_sending_o = sending_c;
  assign bus.qspi_data_o    = data_c;
  assign bus.tx_ready       = tx_ready_c;
  assign bus.underrun       = underrun_q;
  assign bus.qspi_ready_o   = rx_ready_c;
  assign bus.rx_data        = rx_data;
  assign bus.rx_valid       = rx_valid;
  assign bus.rx_drop        = rx_drop;

endmodule

// File: tb/tb_qspi_host_bridge.sv
// Directed bench for qspi_host_bridge: key/data streaming, stalls, underrun, RX reassembly, reset.
module tb_qspi_host_bridge;
  import qspi_pkg::*;

  localparam int unsigned KW = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [3:0] key_nibs [8] = '{4'hB, 4'h4, 4'h3, 4'h5, 4'h2, 4'hB, 4'h9, 4'h3};

  always #5 clk = ~clk;

  qspi_host_bridge_if #(.KEY_WIDTH(KW)) bus ();

  qspi_host_bridge #(.KEY_WIDTH(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a session with the reference key and stream it; ends in WAIT_D
  task automatic key_phase(input int stall_n, input bit poke);
    bus.start        = 1'b1;
    bus.key          = 32'hB435_2B93;
    bus.qspi_ready_i = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    check("prog_pulse", 32'(bus.prog), 1);
    check("busy_set", 32'(bus.busy), 1);
    check("sticky_clr", 32'({bus.underrun, bus.rx_drop}), 0);
    tick(); #1;
    check("prog_one_cycle", 32'(bus.prog), 0);
    tick(); #1;
    check("pre_k_send", 32'(bus.qspi_sending_o), 1);
    check("pre_k_data", 32'(bus.qspi_data_o), 0);
    for (int n = 0; n < 8; n++) begin
      tick();
      if (poke && n == 1) bus.start = 1'b1;
      if (poke && n == 2) bus.start = 1'b0;
      if (n == stall_n) begin
        for (int s = 0; s < 3; s++) begin
          bus.qspi_ready_i = 1'b0;
          #1;
          check("key_hold", 32'(bus.qspi_data_o), 32'(key_nibs[n]));
          tick();
        end
        bus.qspi_ready_i = 1'b1;
      end
      #1;
      check("key_nib", 32'(bus.qspi_data_o), 32'(key_nibs[n]));
      check("key_send", 32'(bus.qspi_sending_o), 1);
      if (poke && n == 2) begin
        check("start_ignored", 32'({bus.prog, bus.busy}), 1);
      end
    end
    tick(); #1;
    check("gap_k", 32'(bus.qspi_sending_o), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.key            = '0;
    bus.tx_data        = '0;
    bus.tx_valid       = 1'b0;
    bus.tx_last        = 1'b0;
    bus.qspi_ready_i   = 1'b0;
    bus.qspi_data_i    = '0;
    bus.qspi_sending_i = 1'b0;
    bus.rx_ready       = 1'b1;
    tick(); tick();
    #1;
    check("rst_ctrl", 32'({bus.prog, bus.busy, bus.done, bus.underrun, bus.rx_drop}), 0);
    check("rst_tx", 32'({bus.qspi_sending_o, bus.qspi_data_o, bus.tx_ready}), 0);
    check("rst_rx", 32'({bus.qspi_ready_o, bus.rx_valid, bus.rx_data}), 32'h200);
    reset = 1'b0;
    tick();

    // Session A: key, then bytes 0x48, 0x69 with a busy start poke
    key_phase(-1, 1'b1);
    bus.tx_data  = 8'h48;
    bus.tx_valid = 1'b1;
    bus.tx_last  = 1'b0;
    #1;
    check("wait_d_no_ack", 32'(bus.tx_ready), 0);
    tick(); #1;
    check("pre_d_send", 32'({bus.qspi_sending_o, bus.tx_ready}), 2);
    tick(); #1;
    check("a_hi0", 32'({bus.qspi_data_o, bus.tx_ready}), 32'h8);
    tick(); #1;
    check("a_lo0", 32'({bus.qspi_data_o, bus.tx_ready}), 32'h11);
    tick();
    bus.tx_data = 8'h69;
    bus.tx_last = 1'b1;
    #1;
    check("a_hi1", 32'({bus.qspi_data_o, bus.tx_ready}), 32'hC);
    tick(); #1;
    check("a_lo1", 32'({bus.qspi_data_o, bus.tx_ready}), 32'h13);
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    #1;
    check("a_end", 32'({bus.done, bus.busy, bus.qspi_sending_o, bus.underrun, bus.tx_ready}), 32'h10);
    tick(); #1;
    check("a_done_once", 32'(bus.done), 0);

    // Session B: stalled key nibble, then stream starves after one byte
    key_phase(3, 1'b0);
    bus.tx_data  = 8'h48;
    bus.tx_valid = 1'b1;
    tick(); tick(); #1;
    check("b_hi0", 32'(bus.qspi_data_o), 4);
    tick(); #1;
    check("b_lo0", 32'({bus.qspi_data_o, bus.tx_ready}), 32'h11);
    tick();
    bus.tx_valid = 1'b0;
    #1;
    check("b_starve", 32'({bus.qspi_sending_o, bus.tx_ready}), 0);
    tick(); #1;
    check("b_underrun_end", 32'({bus.done, bus.underrun}), 3);
    tick(); #1;
    check("b_underrun_sticky", 32'({bus.done, bus.underrun}), 1);

    // RX: A,5,3,C back to back with rx_ready=1
    bus.rx_ready       = 1'b1;
    bus.qspi_sending_i = 1'b1;
    bus.qspi_data_i    = 4'hA;
    tick();
    bus.qspi_data_i = 4'h5;
    tick();
    bus.qspi_data_i = 4'h3;
    #1;
    check("rx_a5", 32'({bus.rx_valid, bus.rx_data}), 32'h1A5);
    tick();
    bus.qspi_data_i = 4'hC;
    #1;
    check("rx_a5_one", 32'(bus.rx_valid), 0);
    tick();
    bus.qspi_sending_i = 1'b0;
    #1;
    check("rx_3c", 32'({bus.rx_valid, bus.rx_data}), 32'h13C);
    tick(); #1;
    check("rx_3c_one", 32'(bus.rx_valid), 0);

    // RX backpressure: 0xA5 held with rx_ready=0
    bus.rx_ready       = 1'b0;
    bus.qspi_sending_i = 1'b1;
    bus.qspi_data_i    = 4'hA;
    tick();
    bus.qspi_data_i = 4'h5;
    tick();
    bus.qspi_sending_i = 1'b0;
    #1;
    check("bp_hold", 32'({bus.rx_valid, bus.qspi_ready_o, bus.rx_data}), 32'h2A5);
    tick(); #1;
    check("bp_hold2", 32'({bus.rx_valid, bus.qspi_ready_o, bus.rx_data}), 32'h2A5);
    tick();
    bus.rx_ready = 1'b1;
    #1;
    check("bp_release", 32'(bus.qspi_ready_o), 1);
    tick(); #1;
    check("bp_taken", 32'(bus.rx_valid), 0);

    // RX half byte then sending falls, then a clean byte proves resync
    bus.qspi_sending_i = 1'b1;
    bus.qspi_data_i    = 4'h6;
    tick();
    bus.qspi_sending_i = 1'b0;
    tick(); #1;
    check("rx_drop", 32'({bus.rx_drop, bus.rx_valid}), 2);
    bus.qspi_sending_i = 1'b1;
    bus.qspi_data_i    = 4'h1;
    tick();
    bus.qspi_data_i = 4'h2;
    tick();
    bus.qspi_sending_i = 1'b0;
    #1;
    check("rx_resync", 32'({bus.rx_valid, bus.rx_data}), 32'h112);

    // Session C: start clears sticky flags, reset mid-KEY aborts
    bus.start        = 1'b1;
    bus.key          = 32'hB435_2B93;
    bus.qspi_ready_i = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    check("c_sticky_clr", 32'({bus.underrun, bus.rx_drop, bus.prog}), 1);
    tick(); tick(); tick(); tick(); #1;
    check("c_mid_key", 32'(bus.qspi_data_o), 4);
    reset = 1'b1;
    tick(); #1;
    check("c_rst_ctrl", 32'({bus.prog, bus.busy, bus.done, bus.underrun, bus.rx_drop}), 0);
    check("c_rst_tx", 32'({bus.qspi_sending_o, bus.qspi_data_o, bus.tx_ready}), 0);
    check("c_rst_rx", 32'({bus.qspi_ready_o, bus.rx_valid, bus.rx_data}), 32'h200);
    reset = 1'b0;
    tick(); tick(); #1;
    check("c_stays_idle", 32'({bus.busy, bus.qspi_sending_o}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
